// File: rtl/pc_branch_unit.sv
// Next-PC stage: branch condition decode, next-PC select and architectural PC register.
// Optional build macro BRANCH_STATS_EN adds br_total/br_taken branch statistics counters.
module pc_branch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_out,
    input  logic            BrEq,
    input  logic            BrLT,
    output logic            BrUn,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            PCSel,
    output logic            halted,
    output logic            misalign
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]     br_total,
    output logic [31:0]     br_taken
`endif
);

    // state  | meaning
    // BOOT   | PC parked at RESET_PC, first fetch gets a full cycle; en=1 -> RUN
    // RUN    | normal sequencing: pc+4 or redirect; misaligned taken target -> HALT
    // HALT   | trapped on misaligned target; PC frozen until rst_n
    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    state_t          state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic            misalign_q;

    logic            is_branch;
    logic            is_jal;
    logic            is_jalr;
    logic            br_cond;
    logic            taken;
    logic            trap;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] target;

    assign is_branch = (opcode == OP_BRANCH);
    assign is_jal    = (opcode == OP_JAL);
    assign is_jalr   = (opcode == OP_JALR);

    always_comb begin
        br_cond = 1'b0;
        case (funct3)
            3'b000:         br_cond = BrEq;
            3'b001:         br_cond = ~BrEq;
            3'b100, 3'b110: br_cond = BrLT;
            3'b101, 3'b111: br_cond = ~BrLT;
            default:        br_cond = 1'b0;
        endcase
    end

    assign taken    = (is_branch & br_cond) | is_jal | is_jalr;

    // JALR clears bit 0 of the sum; only bit 1 can then make a target misaligned
    assign jalr_sum = rs1_out + imm;
    assign target   = is_jalr ? (jalr_sum & ~XLEN'(1)) : (pc_q + imm);
    assign trap     = taken & target[1];

    assign pc_plus4 = pc_q + XLEN'(4);
    assign pc_d     = taken ? target : pc_plus4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_BOOT;
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            case (state_q)
                S_BOOT: begin
                    if (en) begin
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (en) begin
                        if (trap) begin
                            misalign_q <= 1'b1;
                            state_q    <= S_HALT;
                        end else begin
                            pc_q <= pc_d;
                        end
                    end
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
                default: begin
                    state_q <= S_BOOT;
                end
            endcase
        end
    end

    assign BrUn     = is_branch & funct3[1];
    assign PCSel    = taken & (state_q == S_RUN);
    assign pc       = pc_q;
    assign halted   = (state_q == S_HALT);
    assign misalign = misalign_q;

`ifdef BRANCH_STATS_EN
    logic [31:0] br_total_q;
    logic [31:0] br_taken_q;

    // a branch that traps never retires, so it is not counted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_total_q <= 32'd0;
            br_taken_q <= 32'd0;
        end else if ((state_q == S_RUN) && en && is_branch && !trap) begin
            br_total_q <= br_total_q + 32'd1;
            if (br_cond) begin
                br_taken_q <= br_taken_q + 32'd1;
            end
        end
    end

    assign br_total = br_total_q;
    assign br_taken = br_taken_q;
`endif

endmodule

// File: tb/tb_pc_branch_unit.sv
// Randomized self-checking bench for pc_branch_unit against a behavioural next-PC model.
// Honours BRANCH_STATS_EN to also connect and check the statistics counters.
module tb_pc_branch_unit;

    localparam logic [31:0] RST_PC    = 32'h0000_0000;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_JALR   = 7'b1100111;
    localparam logic [6:0]  OP_ALU    = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [6:0]  opcode = 7'd0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] imm = 32'd0;
    logic [31:0] rs1_out = 32'd0;
    logic        BrEq = 1'b0;
    logic        BrLT = 1'b0;
    logic        BrUn;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        PCSel;
    logic        halted;
    logic        misalign;
`ifdef BRANCH_STATS_EN
    logic [31:0] br_total;
    logic [31:0] br_taken;
`endif

    pc_branch_unit #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .opcode   (opcode),
        .funct3   (funct3),
        .imm      (imm),
        .rs1_out  (rs1_out),
        .BrEq     (BrEq),
        .BrLT     (BrLT),
        .BrUn     (BrUn),
        .pc       (pc),
        .pc_plus4 (pc_plus4),
        .PCSel    (PCSel),
        .halted   (halted),
        .misalign (misalign)
`ifdef BRANCH_STATS_EN
        ,
        .br_total (br_total),
        .br_taken (br_taken)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model: boot = neither running nor halted
    logic [31:0] m_pc = RST_PC;
    bit          m_run = 1'b0;
    bit          m_halt = 1'b0;
    bit          m_mis = 1'b0;
    logic [31:0] m_total = 32'd0;
    logic [31:0] m_taken = 32'd0;
    logic        last_pcsel = 1'b0;
    logic        last_brun = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit model_taken(input logic [6:0] op, input logic [2:0] f3,
                                       input bit eq, input bit lt);
        if (op == OP_JAL || op == OP_JALR) return 1'b1;
        if (op != OP_BRANCH) return 1'b0;
        case (f3)
            3'd0:       return eq;
            3'd1:       return !eq;
            3'd4, 3'd6: return lt;
            3'd5, 3'd7: return !lt;
            default:    return 1'b0;
        endcase
    endfunction

    task automatic do_cycle(input bit e, input logic [6:0] op, input logic [2:0] f3,
                            input logic [31:0] im, input logic [31:0] r1,
                            input bit eq, input bit lt);
        bit          tk;
        bit          is_br;
        logic [31:0] tgt;
        @(negedge clk);
        en = e; opcode = op; funct3 = f3; imm = im; rs1_out = r1; BrEq = eq; BrLT = lt;
        is_br = (op == OP_BRANCH);
        tk    = model_taken(op, f3, eq, lt);
        tgt   = (op == OP_JALR) ? ((r1 + im) & 32'hFFFF_FFFE) : (m_pc + im);
        #1;
        check("pc", pc, m_pc);
        check("pc_plus4", pc_plus4, m_pc + 32'd4);
        check("BrUn", 32'(BrUn), 32'(is_br && f3[1]));
        check("PCSel", 32'(PCSel), 32'(tk && m_run));
        check("halted", 32'(halted), 32'(m_halt));
        check("misalign", 32'(misalign), 32'(m_mis));
`ifdef BRANCH_STATS_EN
        check("br_total", br_total, m_total);
        check("br_taken", br_taken, m_taken);
`endif
        last_pcsel = PCSel;
        last_brun  = BrUn;
        @(posedge clk);
        m_mis = 1'b0;
        if (m_halt) begin
            m_halt = 1'b1;
        end else if (!m_run) begin
            if (e) m_run = 1'b1;
        end else if (e) begin
            if (tk && tgt[1]) begin
                m_mis  = 1'b1;
                m_halt = 1'b1;
                m_run  = 1'b0;
            end else begin
                if (is_br) begin
                    m_total = m_total + 32'd1;
                    if (tk) m_taken = m_taken + 32'd1;
                end
                m_pc = tk ? tgt : (m_pc + 32'd4);
            end
        end
    endtask

    task automatic nop(input bit e);
        do_cycle(e, OP_ALU, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        en    = 1'b0;
        #1;
        check("rst_pc", pc, RST_PC);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_misalign", 32'(misalign), 32'd0);
`ifdef BRANCH_STATS_EN
        check("rst_br_total", br_total, 32'd0);
        check("rst_br_taken", br_taken, 32'd0);
`endif
        m_pc = RST_PC; m_run = 1'b0; m_halt = 1'b0; m_mis = 1'b0;
        m_total = 32'd0; m_taken = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic expect_now(input string tag, input logic [31:0] exp_pc,
                              input bit exp_halt, input bit exp_mis);
        #1;
        check({tag, "_pc"}, pc, exp_pc);
        check({tag, "_halted"}, 32'(halted), 32'(exp_halt));
        check({tag, "_misalign"}, 32'(misalign), 32'(exp_mis));
    endtask

    initial begin
        int          halt_cycles;
        int          r;
        bit          e;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] im;
        logic [31:0] r1;

        // start-up: two cycles at RESET_PC, then +4
        do_reset();
        nop(1'b1);
        expect_now("boot", 32'h0, 1'b0, 1'b0);
        nop(1'b1);
        expect_now("run1", 32'h4, 1'b0, 1'b0);
        nop(1'b1);
        expect_now("run2", 32'h8, 1'b0, 1'b0);

        do_cycle(1'b1, OP_JAL, 3'd0, 32'h0000_00F8, 32'd0, 1'b0, 1'b0);
        expect_now("jal_to_100", 32'h100, 1'b0, 1'b0);
        do_cycle(1'b1, OP_BRANCH, 3'b000, 32'd16, 32'd0, 1'b1, 1'b0);
        check("beq_taken_pcsel", 32'(last_pcsel), 32'd1);
        expect_now("beq_taken", 32'h110, 1'b0, 1'b0);
        do_cycle(1'b1, OP_JAL, 3'd0, 32'hFFFF_FFF0, 32'd0, 1'b0, 1'b0);
        do_cycle(1'b1, OP_BRANCH, 3'b000, 32'd16, 32'd0, 1'b0, 1'b0);
        check("beq_nt_pcsel", 32'(last_pcsel), 32'd0);
        expect_now("beq_nt", 32'h104, 1'b0, 1'b0);

        do_cycle(1'b1, OP_BRANCH, 3'b110, 32'd16, 32'd0, 1'b0, 1'b0);
        check("bltu_brun", 32'(last_brun), 32'd1);
        expect_now("bltu_nt", 32'h108, 1'b0, 1'b0);

        do_cycle(1'b1, OP_JAL, 3'd0, 32'h200 - m_pc, 32'd0, 1'b0, 1'b0);
        do_cycle(1'b1, OP_BRANCH, 3'b101, 32'hFFFF_FFF8, 32'd0, 1'b0, 1'b0);
        expect_now("bge_back", 32'h1F8, 1'b0, 1'b0);

        do_cycle(1'b1, OP_JAL, 3'd0, 32'hFFFF_FFFC - m_pc, 32'd0, 1'b0, 1'b0);
        expect_now("jal_top", 32'hFFFF_FFFC, 1'b0, 1'b0);
        do_cycle(1'b0, OP_JAL, 3'd0, 32'd8, 32'd0, 1'b0, 1'b0);
        check("stall_pcsel", 32'(last_pcsel), 32'd1);
        expect_now("stall_jal", 32'hFFFF_FFFC, 1'b0, 1'b0);
        do_cycle(1'b1, OP_JAL, 3'd0, 32'd8, 32'd0, 1'b0, 1'b0);
        expect_now("jal_wrap", 32'h4, 1'b0, 1'b0);

        // misaligned JALR traps and freezes the PC
        do_cycle(1'b1, OP_JALR, 3'd0, 32'd0, 32'h303, 1'b0, 1'b0);
        expect_now("jalr_trap", 32'h4, 1'b1, 1'b1);
        nop(1'b1);
        expect_now("halt_hold", 32'h4, 1'b1, 1'b0);
        do_cycle(1'b1, OP_JAL, 3'd0, 32'd8, 32'd0, 1'b0, 1'b0);
        expect_now("halt_jal", 32'h4, 1'b1, 1'b0);
        do_reset();

        // reset while stalled mid-run
        nop(1'b1); nop(1'b1); nop(1'b1); nop(1'b0);
        do_reset();

`ifdef BRANCH_STATS_EN
        nop(1'b1);
        for (int i = 0; i < 3; i++) do_cycle(1'b1, OP_BRANCH, 3'b000, 32'd8, 32'd0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) do_cycle(1'b1, OP_BRANCH, 3'b001, 32'd8, 32'd0, 1'b1, 1'b0);
        #1;
        check("stats_total", br_total, 32'd5);
        check("stats_taken", br_taken, 32'd3);
        do_reset();
`endif

        halt_cycles = 0;
        for (int i = 0; i < 2500; i++) begin
            if (halt_cycles > 2 || $urandom_range(0, 299) == 0) begin
                do_reset();
                halt_cycles = 0;
            end
            r  = $urandom_range(0, 9);
            e  = ($urandom_range(0, 4) != 0);
            f3 = 3'($urandom);
            im = ($urandom_range(0, 15) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            r1 = ($urandom_range(0, 15) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFD);
            if (r < 5)       op = OP_BRANCH;
            else if (r == 5) op = OP_JAL;
            else if (r == 6) op = OP_JALR;
            else if (r < 9)  op = OP_ALU;
            else             op = 7'($urandom);
            do_cycle(e, op, f3, im, r1, 1'($urandom), 1'($urandom));
            if (m_halt) halt_cycles++;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
